// File: rtl/gen_scope_pipe.sv
// Elastic STAGES-deep pipeline built from named generate scopes stage[i].mix / stage[i].regs.
// Optional output-transfer counter on port out_count is enabled by defining GEN_SCOPE_PIPE_COUNT_EN.
module gen_scope_pipe #(
    parameter int              WIDTH  = 2,
    parameter int              STAGES = 3,
    parameter logic [WIDTH-1:0] KEY   = WIDTH'(2'b11)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef GEN_SCOPE_PIPE_COUNT_EN
    ,
    output logic [7:0]       out_count
`endif
);

    // Per-stage transform: rotate left by one, then XOR with the key.
    function automatic logic [WIDTH-1:0] mix_fn(input logic [WIDTH-1:0] d);
        return {d[WIDTH-2:0], d[WIDTH-1]} ^ KEY;
    endfunction

    for (genvar i = 0; i < STAGES; i++) begin : stage
        logic [WIDTH-1:0] src_data_s;
        logic             src_valid_s;
        logic             adv_s;

        if (i == 0) begin : src_head
            assign src_data_s  = in_data;
            assign src_valid_s = in_valid;
        end else begin : src_chain
            assign src_data_s  = stage[i-1].regs.q;
            assign src_valid_s = stage[i-1].regs.v;
        end

        // Ready ripples backwards: a stage may advance if its successor is empty or advancing.
        if (i == STAGES - 1) begin : adv_tail
            assign adv_s = out_ready;
        end else begin : adv_chain
            assign adv_s = !stage[i+1].regs.v || stage[i+1].adv_s;
        end

        if (1) begin : mix
            logic [WIDTH-1:0] d;
            assign d = mix_fn(src_data_s);
        end

        if (1) begin : regs
            logic             v;
            logic [WIDTH-1:0] q;
            logic             load_s;

            assign load_s = !v || adv_s;

            // Stage register: reset clears, otherwise load whenever the slot is free or draining.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    q <= {WIDTH{1'b0}};
                end else if (load_s) begin
                    v <= src_valid_s;
                    q <= mix.d;
                end else begin
                    v <= v;
                    q <= q;
                end
            end
        end
    end

    assign in_ready  = !stage[0].regs.v || stage[0].adv_s;
    assign out_valid = stage[STAGES-1].regs.v;
    assign out_data  = stage[STAGES-1].regs.q;

`ifdef GEN_SCOPE_PIPE_COUNT_EN
    logic [7:0] count_r;

    // Output transfer counter, wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 8'h00;
        end else if (out_valid && out_ready) begin
            count_r <= count_r + 8'h01;
        end else begin
            count_r <= count_r;
        end
    end

    assign out_count = count_r;
`endif

endmodule

// File: tb/tb_gen_scope_pipe.sv
// Self-checking bench for gen_scope_pipe: directed steps plus randomized traffic against a queue model.
// Define GEN_SCOPE_PIPE_COUNT_EN for both files to also exercise the out_count port.
module tb_gen_scope_pipe;
    localparam int WIDTH  = 2;
    localparam int STAGES = 3;
    localparam int KEYV   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef GEN_SCOPE_PIPE_COUNT_EN
    logic [7:0]       out_count;
`endif

    gen_scope_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .KEY(2'b11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef GEN_SCOPE_PIPE_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int out_xfers = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Whole-pipe reference: rotate-left-and-XOR applied STAGES times, in plain integer arithmetic.
    function automatic logic [WIDTH-1:0] ref_pipe(input logic [WIDTH-1:0] d);
        int x = int'(d);
        int m = 1 << WIDTH;
        for (int s = 0; s < STAGES; s++) begin
            x = (((x * 2) % m) + (x / (m / 2))) ^ KEYV;
        end
        return x[WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check and model at the falling edge, then let the rising edge happen.
    task automatic step();
        logic [WIDTH-1:0] e;
        bit in_x;
        bit out_x;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < STAGES) || out_ready});
        if (out_valid) begin
            chk("out_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        end
        in_x  = in_valid && in_ready;
        out_x = out_valid && out_ready;
        if (out_x && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", {30'd0, out_data}, {30'd0, e});
        end
        if (in_x) exp_q.push_back(ref_pipe(in_data));
        if (out_x) out_xfers++;
        @(posedge clk);
        #1;
`ifdef GEN_SCOPE_PIPE_COUNT_EN
        chk("out_count", {24'd0, out_count}, out_xfers & 32'hFF);
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 2'b00;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        out_xfers = 0;
    endtask

    logic [WIDTH-1:0] stream_exp [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    int guard;

    initial begin
        // Reset values
        do_reset(2);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {30'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency of a single word
        in_valid = 1'b1; in_data = 2'b00; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_c2_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_c3_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_c3_data", {30'd0, out_data}, 32'd3);
        step();

        // Back-to-back streaming
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            in_data  = k[WIDTH-1:0];
            if (k < 4) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            if (k >= 2) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_data", {30'd0, out_data}, {30'd0, stream_exp[k-2]});
            end
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Backpressure: fill, hold, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = WIDTH'($urandom_range(3, 0));
            step();
        end
        chk("bp_accepted", exp_q.size(), STAGES);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("bp_drained", exp_q.size(), 32'd0);

        // Mid-flight reset discards in-flight words
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = WIDTH'($urandom_range(3, 0));
            step();
        end
        do_reset(1);
        out_ready = 1'b1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mrst_no_emit", {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            in_data   = WIDTH'($urandom_range(3, 0));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("rand_drained", exp_q.size(), 32'd0);
        step();
        chk("rand_idle_valid", {31'd0, out_valid}, 32'd0);

`ifdef GEN_SCOPE_PIPE_COUNT_EN
        // Counter wrap after 257 transfers
        do_reset(2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (out_xfers < 257 && guard < 300) begin
            in_data = WIDTH'($urandom_range(3, 0));
            step();
            guard++;
        end
        chk("count_257", {24'd0, out_count}, 32'h01);
        in_valid = 1'b0;
        repeat (4) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
